input_port_buffer: RTL and testbench

Write-side companion of the router crossbar: one instance per router input port. It accepts flits from the upstream link and stores them in per-virtual-channel FIFOs. It presents each VC's head flit to the crossbar and switch allocator, and pops on allocator grant. It returns one credit upstream per popped flit.

---
 rtl/input_port_buffer.sv | 119 +++++++++++
 tb/tb_input_port_buffer.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/input_port_buffer.sv
// input_port_buffer: per-VC input FIFOs with write-side packet FSM and credit return.
// Define INPUT_BUFFER_CHECK_EN to compile in the sticky protocol-error detector.
package input_port_buffer_pkg;
    typedef enum logic [1:0] {HEAD = 2'd0, BODY = 2'd1, TAIL = 2'd2, HEADTAIL = 2'd3} flit_label_t;
    typedef struct packed {
        flit_label_t flit_label;
        logic [3:0]  vc_id;
        logic [15:0] payload;
    } flit_t;
endpackage

module input_port_buffer
    import input_port_buffer_pkg::*;
#(
    parameter int VC_NUM      = 2,
    parameter int BUFFER_SIZE = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  flit_t             data_i,
    input  logic              valid_i,
    input  logic [VC_NUM-1:0] read_i,
    output flit_t             flit_o [VC_NUM],
    output logic [VC_NUM-1:0] valid_o,
    output logic [VC_NUM-1:0] is_head_o,
    output logic [VC_NUM-1:0] credit_o,
    output logic [VC_NUM-1:0] packet_open_o,
    output logic              error_o
);
    localparam int PW = $clog2(BUFFER_SIZE);
    localparam int CW = PW + 1;

    typedef enum logic {IDLE, OPEN} state_t;

    state_t          state_q  [VC_NUM];
    state_t          state_d  [VC_NUM];
    logic [PW-1:0]   rd_ptr_q [VC_NUM];
    logic [PW-1:0]   rd_ptr_d [VC_NUM];
    logic [PW-1:0]   wr_ptr_q [VC_NUM];
    logic [PW-1:0]   wr_ptr_d [VC_NUM];
    logic [CW-1:0]   count_q  [VC_NUM];
    logic [CW-1:0]   count_d  [VC_NUM];
    flit_t           mem_q    [VC_NUM][BUFFER_SIZE];
    logic [VC_NUM-1:0] hit, full, pop, push, credit_q;

    for (genvar g = 0; g < VC_NUM; g++) begin : g_vc
        assign valid_o[g]       = count_q[g] != '0;
        assign flit_o[g]        = mem_q[g][rd_ptr_q[g]];
        assign is_head_o[g]     = valid_o[g] && (flit_o[g].flit_label == HEAD || flit_o[g].flit_label == HEADTAIL);
        assign packet_open_o[g] = state_q[g] == OPEN;
    end

    assign credit_o = credit_q;

    // A full FIFO still accepts when its head leaves in the same cycle.
    always_comb begin
        for (int v = 0; v < VC_NUM; v++) begin
            hit[v]      = valid_i && (32'(data_i.vc_id) == v);
            full[v]     = count_q[v] == CW'(BUFFER_SIZE);
            pop[v]      = read_i[v] && valid_o[v];
            push[v]     = hit[v] && (!full[v] || pop[v]);
            rd_ptr_d[v] = pop[v] ? rd_ptr_q[v] + PW'(1) : rd_ptr_q[v];
            wr_ptr_d[v] = push[v] ? wr_ptr_q[v] + PW'(1) : wr_ptr_q[v];
            count_d[v]  = count_q[v] + CW'(push[v]) - CW'(pop[v]);
            state_d[v]  = state_q[v];
            if (push[v])
                state_d[v] = (state_q[v] == IDLE) ? ((data_i.flit_label == HEAD) ? OPEN : IDLE)
                                                  : ((data_i.flit_label == TAIL) ? IDLE : OPEN);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int v = 0; v < VC_NUM; v++) begin
                rd_ptr_q[v] <= '0;
                wr_ptr_q[v] <= '0;
                count_q[v]  <= '0;
                state_q[v]  <= IDLE;
            end
            credit_q <= '0;
        end else begin
            for (int v = 0; v < VC_NUM; v++) begin
                rd_ptr_q[v] <= rd_ptr_d[v];
                wr_ptr_q[v] <= wr_ptr_d[v];
                count_q[v]  <= count_d[v];
                state_q[v]  <= state_d[v];
            end
            credit_q <= pop;
        end
    end

    always_ff @(posedge clk) begin
        for (int v = 0; v < VC_NUM; v++)
            if (push[v]) mem_q[v][wr_ptr_q[v]] <= data_i;
    end

`ifdef INPUT_BUFFER_CHECK_EN
    logic head_lbl, error_d, error_q;

    assign head_lbl = data_i.flit_label == HEAD || data_i.flit_label == HEADTAIL;

    always_comb begin
        error_d = error_q || (valid_i && (32'(data_i.vc_id) >= VC_NUM));
        for (int v = 0; v < VC_NUM; v++)
            if (hit[v])
                error_d = error_d || (state_q[v] == OPEN && head_lbl) ||
                          (state_q[v] == IDLE && !head_lbl) || (full[v] && !pop[v]);
    end

    always_ff @(posedge clk) begin
        if (rst) error_q <= 1'b0;
        else     error_q <= error_d;
    end

    assign error_o = error_q;
`else
    assign error_o = 1'b0;
`endif
endmodule

// File: tb/tb_input_port_buffer.sv
// tb_input_port_buffer: directed stimulus with a per-VC expected-flit scoreboard checked on every pop.
module tb_input_port_buffer;
    import input_port_buffer_pkg::*;

`ifdef INPUT_BUFFER_CHECK_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    flit_t      data_i = '0;
    logic       valid_i = 1'b0;
    logic [1:0] read_i = 2'b00;
    flit_t      flit_o [2];
    logic [1:0] valid_o, is_head_o, credit_o, packet_open_o;
    logic       error_o;

    int    tests = 0;
    int    failed = 0;
    int    cred_cnt [2] = '{0, 0};
    int    base;
    flit_t q0[$];
    flit_t q1[$];

    always #5 clk = ~clk;

    input_port_buffer #(.VC_NUM(2), .BUFFER_SIZE(4)) dut (
        .clk(clk), .rst(rst), .data_i(data_i), .valid_i(valid_i), .read_i(read_i),
        .flit_o(flit_o), .valid_o(valid_o), .is_head_o(is_head_o), .credit_o(credit_o),
        .packet_open_o(packet_open_o), .error_o(error_o)
    );

    function automatic flit_t mk(flit_label_t l, int vc, int p);
        flit_t f;
        f.flit_label = l;
        f.vc_id      = 4'(vc);
        f.payload    = 16'(p);
        return f;
    endfunction

    task automatic chk(string n, logic [31:0] a, logic [31:0] e);
        tests++;
        if (a !== e) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", n, a, e);
        end
    endtask

    task automatic step(logic v, flit_t f, logic [1:0] rd, bit exp_push);
        valid_i = v;
        data_i  = f;
        read_i  = rd;
        if (exp_push) begin
            if (f.vc_id == 4'd0) q0.push_back(f);
            else                 q1.push_back(f);
        end
        @(posedge clk);
        #1;
        valid_i = 1'b0;
        read_i  = 2'b00;
    endtask

    task automatic idle();
        step(1'b0, '0, 2'b00, 1'b0);
    endtask

    // Scoreboard monitor: every pop the DUT will perform at the next edge is checked here.
    always @(negedge clk) begin
        if (!rst) begin
            for (int v = 0; v < 2; v++) begin
                if (credit_o[v]) cred_cnt[v]++;
                if (read_i[v] && valid_o[v]) begin
                    flit_t e;
                    tests++;
                    if ((v == 0 ? q0.size() : q1.size()) == 0) begin
                        failed++;
                        $display("FAIL pop_vc%0d: got %0h expected nothing queued", v, flit_o[v]);
                    end else begin
                        e = (v == 0) ? q0.pop_front() : q1.pop_front();
                        if (flit_o[v] !== e) begin
                            failed++;
                            $display("FAIL pop_vc%0d: got %0h expected %0h", v, flit_o[v], e);
                        end
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        idle();
        idle();
        rst = 1'b0;
        chk("rst_valid", 32'(valid_o), 0);
        chk("rst_is_head", 32'(is_head_o), 0);
        chk("rst_credit", 32'(credit_o), 0);
        chk("rst_open", 32'(packet_open_o), 0);
        chk("rst_error", 32'(error_o), 0);

        step(1'b1, mk(HEAD, 0, 'h100), 2'b00, 1'b1);
        chk("head_valid", 32'(valid_o), 1);
        chk("head_is_head", 32'(is_head_o), 1);
        chk("head_open", 32'(packet_open_o), 1);

        step(1'b1, mk(HEAD, 1, 'h200), 2'b00, 1'b1);
        step(1'b1, mk(BODY, 1, 'h201), 2'b00, 1'b1);
        step(1'b1, mk(BODY, 1, 'h202), 2'b00, 1'b1);
        step(1'b1, mk(TAIL, 1, 'h203), 2'b00, 1'b1);
        chk("fill_valid", 32'(valid_o), 3);
        chk("fill_open", 32'(packet_open_o), 1);
        chk("fill_error", 32'(error_o), 0);
        step(1'b1, mk(HEADTAIL, 1, 'h204), 2'b00, 1'b0);
        chk("drop_error", 32'(error_o), 32'(EXP_ERR));
        for (int i = 0; i < 4; i++) step(1'b0, '0, 2'b10, 1'b0);
        chk("drain1_valid", 32'(valid_o), 1);
        idle();
        chk("drain1_credits", cred_cnt[1], 4);

        step(1'b1, mk(BODY, 0, 'h101), 2'b00, 1'b1);
        step(1'b1, mk(BODY, 0, 'h102), 2'b00, 1'b1);
        step(1'b1, mk(BODY, 0, 'h103), 2'b00, 1'b1);
        step(1'b1, mk(TAIL, 0, 'h104), 2'b01, 1'b1);
        chk("simul_credit", 32'(credit_o), 1);
        chk("simul_open", 32'(packet_open_o), 0);
        idle();
        chk("simul_credit_off", 32'(credit_o), 0);
        for (int i = 0; i < 3; i++) step(1'b0, '0, 2'b01, 1'b0);
        chk("simul_still_one", 32'(valid_o), 1);
        step(1'b0, '0, 2'b01, 1'b0);
        chk("simul_empty", 32'(valid_o), 0);
        idle();

        base = cred_cnt[0];
        for (int k = 0; k < 10; k++) step(1'b1, mk(HEADTAIL, 0, 'h300 + k), (k > 0) ? 2'b01 : 2'b00, 1'b1);
        step(1'b0, '0, 2'b01, 1'b0);
        idle();
        chk("wrap_credits", cred_cnt[0] - base, 10);
        chk("wrap_valid", 32'(valid_o), 0);
        chk("wrap_open", 32'(packet_open_o), 0);

        rst = 1'b1;
        idle();
        rst = 1'b0;
        chk("proto_rst_error", 32'(error_o), 0);
        step(1'b1, mk(HEADTAIL, 5, 'h4ff), 2'b00, 1'b0);
        chk("badvc_valid", 32'(valid_o), 0);
        chk("badvc_error", 32'(error_o), 32'(EXP_ERR));
        rst = 1'b1;
        idle();
        rst = 1'b0;
        step(1'b1, mk(BODY, 1, 'h400), 2'b00, 1'b1);
        chk("body_idle_error", 32'(error_o), 32'(EXP_ERR));
        step(1'b1, mk(HEADTAIL, 0, 'h401), 2'b00, 1'b1);
        chk("headtail_open", 32'(packet_open_o), 0);
        chk("proto_valid", 32'(valid_o), 3);
        chk("proto_is_head", 32'(is_head_o), 1);
        step(1'b0, '0, 2'b11, 1'b0);
        chk("proto_credit", 32'(credit_o), 3);
        step(1'b0, '0, 2'b10, 1'b0);
        chk("empty_read_credit", 32'(credit_o), 0);
        chk("proto_empty", 32'(valid_o), 0);

        rst = 1'b1;
        idle();
        rst = 1'b0;
        step(1'b1, mk(HEAD, 0, 'h500), 2'b00, 1'b1);
        step(1'b1, mk(BODY, 0, 'h501), 2'b00, 1'b1);
        step(1'b1, mk(BODY, 0, 'h502), 2'b00, 1'b1);
        chk("mid_valid", 32'(valid_o), 1);
        chk("mid_open", 32'(packet_open_o), 1);
        rst = 1'b1;
        idle();
        rst = 1'b0;
        q0.delete();
        chk("midrst_valid", 32'(valid_o), 0);
        chk("midrst_open", 32'(packet_open_o), 0);
        chk("midrst_credit", 32'(credit_o), 0);
        chk("midrst_error", 32'(error_o), 0);
        idle();
        chk("midrst_credit_after", 32'(credit_o), 0);

        chk("q0_empty", q0.size(), 0);
        chk("q1_empty", q1.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
